// File: rtl/mips_control_unit_if.sv
// Control/status bundle between the multicycle control FSM
// and the MIPS-subset datapath.
interface mips_control_unit_if;
  logic [5:0]  opcode;
  logic [15:0] immediate;
  logic        overflow;
  logic        zero_div;
  logic        mult_stop;
  logic        div_stop;
  logic        div_zero;

  logic       mux_memory_wd;
  logic       mux_b;
  logic       mux_high;
  logic       mux_low;
  logic       mux_extend;
  logic       mux_shift_src;
  logic [1:0] mux_shift_amt;
  logic [1:0] mux_a;
  logic [1:0] mux_ula1;
  logic [1:0] mux_ula2;
  logic [1:0] mux_pc;
  logic [1:0] mux_register_wr;
  logic [2:0] mux_address;
  logic [2:0] mux_register_wd;
  logic       address_rg_load;
  logic       epc_load;
  logic       mdr_load;
  logic       ir_load;
  logic       high_load;
  logic       low_load;
  logic       a_load;
  logic       b_load;
  logic       ula_out_load;
  logic       store_size;
  logic [1:0] load_size;
  logic       memory_wr;
  logic       reg_wr;
  logic       pc_write;
  logic       is_beq;
  logic       is_bne;
  logic [2:0] ula;
  logic [2:0] shift;
  logic       mult_init;
  logic       div_init;

  modport master (
    input  opcode, immediate, overflow, zero_div,
    input  mult_stop, div_stop, div_zero,
    output mux_memory_wd, mux_b, mux_high, mux_low,
    output mux_extend, mux_shift_src, mux_shift_amt,
    output mux_a, mux_ula1, mux_ula2, mux_pc,
    output mux_register_wr, mux_address, mux_register_wd,
    output address_rg_load, epc_load, mdr_load, ir_load,
    output high_load, low_load, a_load, b_load,
    output ula_out_load, store_size, load_size,
    output memory_wr, reg_wr, pc_write, is_beq, is_bne,
    output ula, shift, mult_init, div_init
  );

  modport slave (
    output opcode, immediate, overflow, zero_div,
    output mult_stop, div_stop, div_zero,
    input  mux_memory_wd, mux_b, mux_high, mux_low,
    input  mux_extend, mux_shift_src, mux_shift_amt,
    input  mux_a, mux_ula1, mux_ula2, mux_pc,
    input  mux_register_wr, mux_address, mux_register_wd,
    input  address_rg_load, epc_load, mdr_load, ir_load,
    input  high_load, low_load, a_load, b_load,
    input  ula_out_load, store_size, load_size,
    input  memory_wr, reg_wr, pc_write, is_beq, is_bne,
    input  ula, shift, mult_init, div_init
  );
endinterface

// File: rtl/mips_control_unit.sv
// Multicycle Moore control FSM for the MIPS-subset datapath.
// Define CU_MULT_DIV_EN to enable the mult/div sequences.
module mips_control_unit (
  input logic                 clk,
  input logic                 reset_in,
  mips_control_unit_if.master bus
);

  typedef enum logic [5:0] {
    S_RESET, S_F1, S_F2, S_F3, S_DEC,
    S_ADD, S_SUB, S_AND, S_SLT, S_RWB,
    S_SH1L, S_SH1R, S_SLL, S_SRA, S_SHWB,
    S_JR, S_MFHI, S_MFLO,
    S_MUL_INIT, S_MUL_WAIT, S_MUL_ST,
    S_DIV_INIT, S_DIV_WAIT, S_DIV_ST,
    S_X1, S_X2,
    S_ADDI, S_IWB, S_BEQ, S_BNE,
    S_MADDR, S_LW1, S_LW2, S_LW3, S_LWB, S_SWM,
    S_LUI, S_J, S_JAL,
    S_EXC1, S_EXC2, S_EXC3, S_EXC4
  } state_t;

  localparam logic [2:0] V_INV  = 3'd2;
  localparam logic [2:0] V_OVF  = 3'd3;
  localparam logic [2:0] V_DIVZ = 3'd4;

  state_t     state, state_nxt;
  logic [2:0] vec, vec_nxt;
  logic [5:0] funct;
  logic [5:0] op;
  logic       r_type;
  logic       unused_bits;

  assign funct  = bus.immediate[5:0];
  assign op     = bus.opcode;
  assign r_type = op == 6'h00;
  // shamt and the zero flag are consumed by the datapath
  assign unused_bits = ^{bus.zero_div, bus.immediate[15:6]};

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state <= S_RESET;
      vec   <= 3'd0;
    end else begin
      state <= state_nxt;
      vec   <= vec_nxt;
    end
  end

  always_comb begin
    state_nxt = S_F1;
    vec_nxt   = vec;
    unique case (state)
      S_F1: state_nxt = S_F2;
      S_F2: state_nxt = S_F3;
      S_F3: state_nxt = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          r_type && funct == 6'h20: state_nxt = S_ADD;
          r_type && funct == 6'h22: state_nxt = S_SUB;
          r_type && funct == 6'h24: state_nxt = S_AND;
          r_type && funct == 6'h2A: state_nxt = S_SLT;
          r_type && funct == 6'h00: state_nxt = S_SH1L;
          r_type && funct == 6'h03: state_nxt = S_SH1R;
          r_type && funct == 6'h08: state_nxt = S_JR;
          r_type && funct == 6'h10: state_nxt = S_MFHI;
          r_type && funct == 6'h12: state_nxt = S_MFLO;
`ifdef CU_MULT_DIV_EN
          r_type && funct == 6'h18: state_nxt = S_MUL_INIT;
          r_type && funct == 6'h1A: state_nxt = S_DIV_INIT;
`endif
          r_type && funct == 6'h05: state_nxt = S_X1;
          op == 6'h08: state_nxt = S_ADDI;
          op == 6'h04: state_nxt = S_BEQ;
          op == 6'h05: state_nxt = S_BNE;
          op == 6'h23: state_nxt = S_MADDR;
          op == 6'h2B: state_nxt = S_MADDR;
          op == 6'h0F: state_nxt = S_LUI;
          op == 6'h02: state_nxt = S_J;
          op == 6'h03: state_nxt = S_JAL;
          default: begin
            state_nxt = S_EXC1;
            vec_nxt   = V_INV;
          end
        endcase
      end
      S_ADD, S_SUB, S_ADDI: begin
        if (bus.overflow) begin
          state_nxt = S_EXC1;
          vec_nxt   = V_OVF;
        end else begin
          state_nxt = state == S_ADDI ? S_IWB : S_RWB;
        end
      end
      S_AND, S_SLT: state_nxt = S_RWB;
      S_SH1L: state_nxt = S_SLL;
      S_SH1R: state_nxt = S_SRA;
      S_SLL, S_SRA: state_nxt = S_SHWB;
      S_MUL_INIT: state_nxt = S_MUL_WAIT;
      S_MUL_WAIT:
        state_nxt = bus.mult_stop ? S_MUL_ST : S_MUL_WAIT;
      S_DIV_INIT: state_nxt = S_DIV_WAIT;
      S_DIV_WAIT: begin
        // a zero divisor wins over a simultaneous done
        if (bus.div_zero) begin
          state_nxt = S_EXC1;
          vec_nxt   = V_DIVZ;
        end else begin
          state_nxt = bus.div_stop ? S_DIV_ST : S_DIV_WAIT;
        end
      end
      S_X1: state_nxt = S_X2;
      S_MADDR: state_nxt = op == 6'h23 ? S_LW1 : S_SWM;
      S_LW1: state_nxt = S_LW2;
      S_LW2: state_nxt = S_LW3;
      S_LW3: state_nxt = S_LWB;
      S_JAL: state_nxt = S_J;
      S_EXC1: state_nxt = S_EXC2;
      S_EXC2: state_nxt = S_EXC3;
      S_EXC3: state_nxt = S_EXC4;
      default: state_nxt = S_F1;
    endcase
  end

  always_comb begin
    bus.mux_memory_wd   = 1'b0;
    bus.mux_b           = 1'b0;
    bus.mux_high        = 1'b0;
    bus.mux_low         = 1'b0;
    bus.mux_extend      = 1'b0;
    bus.mux_shift_src   = 1'b0;
    bus.mux_shift_amt   = 2'b00;
    bus.mux_a           = 2'b00;
    bus.mux_ula1        = 2'b00;
    bus.mux_ula2        = 2'b00;
    bus.mux_pc          = 2'b00;
    bus.mux_register_wr = 2'b00;
    bus.mux_address     = 3'b000;
    bus.mux_register_wd = 3'b000;
    bus.address_rg_load = 1'b0;
    bus.epc_load        = 1'b0;
    bus.mdr_load        = 1'b0;
    bus.ir_load         = 1'b0;
    bus.high_load       = 1'b0;
    bus.low_load        = 1'b0;
    bus.a_load          = 1'b0;
    bus.b_load          = 1'b0;
    bus.ula_out_load    = 1'b0;
    bus.store_size      = 1'b0;
    bus.load_size       = 2'b00;
    bus.memory_wr       = 1'b0;
    bus.reg_wr          = 1'b0;
    bus.pc_write        = 1'b0;
    bus.is_beq          = 1'b0;
    bus.is_bne          = 1'b0;
    bus.ula             = 3'b000;
    bus.shift           = 3'b000;
    bus.mult_init       = 1'b0;
    bus.div_init        = 1'b0;
    unique case (state)
      S_F1, S_F2, S_F3: begin
        bus.ula      = 3'b001;
        bus.mux_ula1 = 2'b01;
        bus.mux_ula2 = 2'b01;
        bus.ir_load  = state == S_F3;
        bus.pc_write = state == S_F3;
      end
      S_DEC: begin
        bus.a_load       = 1'b1;
        bus.b_load       = 1'b1;
        bus.ula          = 3'b001;
        bus.mux_ula1     = 2'b01;
        bus.mux_ula2     = 2'b11;
        bus.ula_out_load = 1'b1;
      end
      S_ADD, S_SUB, S_AND, S_SLT: begin
        bus.ula_out_load = 1'b1;
        unique case (state)
          S_ADD:   bus.ula = 3'b001;
          S_SUB:   bus.ula = 3'b010;
          S_AND:   bus.ula = 3'b011;
          default: bus.ula = 3'b111;
        endcase
      end
      S_RWB: begin
        bus.reg_wr          = 1'b1;
        bus.mux_register_wr = 2'b01;
      end
      S_SH1L, S_SH1R: bus.shift = 3'b001;
      S_SLL: bus.shift = 3'b010;
      S_SRA: bus.shift = 3'b100;
      S_SHWB: begin
        bus.reg_wr          = 1'b1;
        bus.mux_register_wr = 2'b01;
        bus.mux_register_wd = 3'b100;
      end
      S_JR: bus.pc_write = 1'b1;
      S_MFHI, S_MFLO: begin
        bus.reg_wr          = 1'b1;
        bus.mux_register_wr = 2'b01;
        bus.mux_register_wd = state == S_MFHI ? 3'b010 : 3'b011;
      end
`ifdef CU_MULT_DIV_EN
      S_MUL_INIT: bus.mult_init = 1'b1;
      S_DIV_INIT: bus.div_init = 1'b1;
      S_MUL_ST, S_DIV_ST: begin
        bus.high_load = 1'b1;
        bus.low_load  = 1'b1;
        bus.mux_high  = state == S_DIV_ST;
        bus.mux_low   = state == S_DIV_ST;
      end
`endif
      S_X1: begin
        bus.ula_out_load    = 1'b1;
        bus.reg_wr          = 1'b1;
        bus.mux_register_wr = 2'b11;
        bus.mux_register_wd = 3'b111;
      end
      S_X2, S_IWB: bus.reg_wr = 1'b1;
      S_ADDI, S_MADDR: begin
        bus.ula          = 3'b001;
        bus.mux_ula2     = 2'b10;
        bus.ula_out_load = 1'b1;
      end
      S_BEQ, S_BNE: begin
        bus.ula    = 3'b010;
        bus.mux_pc = 2'b01;
        bus.is_beq = state == S_BEQ;
        bus.is_bne = state == S_BNE;
      end
      S_LW1, S_LW2, S_LW3: begin
        bus.mux_address = 3'b001;
        bus.mdr_load    = state == S_LW3;
      end
      S_LWB: begin
        bus.reg_wr          = 1'b1;
        bus.mux_register_wd = 3'b001;
      end
      S_SWM: begin
        bus.mux_address = 3'b001;
        bus.memory_wr   = 1'b1;
      end
      S_LUI: begin
        bus.reg_wr          = 1'b1;
        bus.mux_register_wd = 3'b101;
      end
      S_J: begin
        bus.mux_pc   = 2'b10;
        bus.pc_write = 1'b1;
      end
      S_JAL: begin
        bus.reg_wr          = 1'b1;
        bus.mux_register_wr = 2'b10;
        bus.mux_register_wd = 3'b110;
      end
      S_EXC1: begin
        bus.epc_load    = 1'b1;
        bus.ula         = 3'b010;
        bus.mux_ula1    = 2'b01;
        bus.mux_ula2    = 2'b01;
        bus.mux_address = vec;
      end
      S_EXC2, S_EXC3: begin
        bus.mux_address = vec;
        bus.mdr_load    = state == S_EXC3;
      end
      S_EXC4: begin
        bus.mux_extend = 1'b1;
        bus.mux_pc     = 2'b11;
        bus.pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Randomized bench: per-instruction expected output traces are
// built from the instruction rules and compared every cycle.
module tb_mips_control_unit;

  typedef struct packed {
    logic       mux_memory_wd, mux_b, mux_high, mux_low;
    logic       mux_extend, mux_shift_src;
    logic [1:0] mux_shift_amt, mux_a, mux_ula1, mux_ula2;
    logic [1:0] mux_pc, mux_register_wr;
    logic [2:0] mux_address, mux_register_wd;
    logic       address_rg_load, epc_load, mdr_load, ir_load;
    logic       high_load, low_load, a_load, b_load;
    logic       ula_out_load, store_size;
    logic [1:0] load_size;
    logic       memory_wr, reg_wr, pc_write, is_beq, is_bne;
    logic [2:0] ula, shift;
    logic       mult_init, div_init;
  } ctl_t;

  logic clk = 1'b0;
  logic reset_in;
  mips_control_unit_if bus ();

  mips_control_unit dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  ctl_t       got;
  ctl_t       e_c;
  ctl_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         step = 0;
  bit         armed = 1'b0;
  logic [5:0] cur_op, cur_fn;
  logic [5:0] rfn [0:12];
  logic [5:0] iop [0:8];

  always_comb begin
    got = '0;
    got.mux_memory_wd   = bus.mux_memory_wd;
    got.mux_b           = bus.mux_b;
    got.mux_high        = bus.mux_high;
    got.mux_low         = bus.mux_low;
    got.mux_extend      = bus.mux_extend;
    got.mux_shift_src   = bus.mux_shift_src;
    got.mux_shift_amt   = bus.mux_shift_amt;
    got.mux_a           = bus.mux_a;
    got.mux_ula1        = bus.mux_ula1;
    got.mux_ula2        = bus.mux_ula2;
    got.mux_pc          = bus.mux_pc;
    got.mux_register_wr = bus.mux_register_wr;
    got.mux_address     = bus.mux_address;
    got.mux_register_wd = bus.mux_register_wd;
    got.address_rg_load = bus.address_rg_load;
    got.epc_load        = bus.epc_load;
    got.mdr_load        = bus.mdr_load;
    got.ir_load         = bus.ir_load;
    got.high_load       = bus.high_load;
    got.low_load        = bus.low_load;
    got.a_load          = bus.a_load;
    got.b_load          = bus.b_load;
    got.ula_out_load    = bus.ula_out_load;
    got.store_size      = bus.store_size;
    got.load_size       = bus.load_size;
    got.memory_wr       = bus.memory_wr;
    got.reg_wr          = bus.reg_wr;
    got.pc_write        = bus.pc_write;
    got.is_beq          = bus.is_beq;
    got.is_bne          = bus.is_bne;
    got.ula             = bus.ula;
    got.shift           = bus.shift;
    got.mult_init       = bus.mult_init;
    got.div_init        = bus.div_init;
  end

  function automatic void push_wb(input logic [1:0] wr,
                                  input logic [2:0] wd);
    ctl_t c = '0;
    c.reg_wr          = 1'b1;
    c.mux_register_wr = wr;
    c.mux_register_wd = wd;
    exp_q.push_back(c);
  endfunction

  // Expected output trace of one instruction, FETCH1 onwards.
  function automatic void build(input logic [5:0] op,
                                input logic [5:0] fn,
                                input bit ovf, input int w,
                                input bit dzo, input int dz);
    ctl_t c;
    logic [2:0] v = 3'd0;
    exp_q.delete();
    c = '0;
    c.ula = 3'b001; c.mux_ula1 = 2'b01; c.mux_ula2 = 2'b01;
    exp_q.push_back(c);
    exp_q.push_back(c);
    c.ir_load = 1'b1; c.pc_write = 1'b1;
    exp_q.push_back(c);
    c = '0;
    c.a_load = 1'b1; c.b_load = 1'b1; c.ula = 3'b001;
    c.mux_ula1 = 2'b01; c.mux_ula2 = 2'b11;
    c.ula_out_load = 1'b1;
    exp_q.push_back(c);
    c = '0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h22, 6'h24, 6'h2A: begin
          c.ula_out_load = 1'b1;
          c.ula = fn == 6'h20 ? 3'b001 :
                  fn == 6'h22 ? 3'b010 :
                  fn == 6'h24 ? 3'b011 : 3'b111;
          exp_q.push_back(c);
          if (ovf && (fn == 6'h20 || fn == 6'h22)) v = 3'd3;
          else push_wb(2'b01, 3'b000);
        end
        6'h00, 6'h03: begin
          c.shift = 3'b001;
          exp_q.push_back(c);
          c.shift = fn == 6'h00 ? 3'b010 : 3'b100;
          exp_q.push_back(c);
          push_wb(2'b01, 3'b100);
        end
        6'h08: begin
          c.pc_write = 1'b1;
          exp_q.push_back(c);
        end
        6'h10: push_wb(2'b01, 3'b010);
        6'h12: push_wb(2'b01, 3'b011);
`ifdef CU_MULT_DIV_EN
        6'h18: begin
          c.mult_init = 1'b1;
          exp_q.push_back(c);
          c = '0;
          repeat (w + 1) exp_q.push_back(c);
          c.high_load = 1'b1; c.low_load = 1'b1;
          exp_q.push_back(c);
        end
        6'h1A: begin
          c.div_init = 1'b1;
          exp_q.push_back(c);
          c = '0;
          if (dzo && dz <= w) begin
            repeat (dz + 1) exp_q.push_back(c);
            v = 3'd4;
          end else begin
            repeat (w + 1) exp_q.push_back(c);
            c.high_load = 1'b1; c.low_load = 1'b1;
            c.mux_high = 1'b1; c.mux_low = 1'b1;
            exp_q.push_back(c);
          end
        end
`endif
        6'h05: begin
          c.ula_out_load = 1'b1; c.reg_wr = 1'b1;
          c.mux_register_wr = 2'b11;
          c.mux_register_wd = 3'b111;
          exp_q.push_back(c);
          push_wb(2'b00, 3'b000);
        end
        default: v = 3'd2;
      endcase
    end else begin
      case (op)
        6'h08, 6'h23, 6'h2B: begin
          c.ula = 3'b001; c.mux_ula2 = 2'b10;
          c.ula_out_load = 1'b1;
          exp_q.push_back(c);
          c = '0;
          if (op == 6'h08) begin
            if (ovf) v = 3'd3;
            else push_wb(2'b00, 3'b000);
          end else if (op == 6'h2B) begin
            c.mux_address = 3'd1; c.memory_wr = 1'b1;
            exp_q.push_back(c);
          end else begin
            c.mux_address = 3'd1;
            exp_q.push_back(c);
            exp_q.push_back(c);
            c.mdr_load = 1'b1;
            exp_q.push_back(c);
            push_wb(2'b00, 3'b001);
          end
        end
        6'h04, 6'h05: begin
          c.ula = 3'b010; c.mux_pc = 2'b01;
          c.is_beq = op == 6'h04;
          c.is_bne = op == 6'h05;
          exp_q.push_back(c);
        end
        6'h0F: push_wb(2'b00, 3'b101);
        6'h02, 6'h03: begin
          if (op == 6'h03) push_wb(2'b10, 3'b110);
          c.mux_pc = 2'b10; c.pc_write = 1'b1;
          exp_q.push_back(c);
        end
        default: v = 3'd2;
      endcase
    end
    if (v != 3'd0) begin
      c = '0;
      c.epc_load = 1'b1; c.ula = 3'b010;
      c.mux_ula1 = 2'b01; c.mux_ula2 = 2'b01;
      c.mux_address = v;
      exp_q.push_back(c);
      c = '0;
      c.mux_address = v;
      exp_q.push_back(c);
      c.mdr_load = 1'b1;
      exp_q.push_back(c);
      c = '0;
      c.mux_extend = 1'b1; c.mux_pc = 2'b11;
      c.pc_write = 1'b1;
      exp_q.push_back(c);
    end
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s outputs %h expected 0", nm, got);
    end
  endtask

  always @(negedge clk) begin
    if (armed && exp_q.size() > 0) begin
      e_c = exp_q.pop_front();
      checks++;
      if (got !== e_c) begin
        errors++;
        $display("FAIL trace op=%h fn=%h step=%0d got=%h exp=%h",
                 cur_op, cur_fn, step, got, e_c);
      end
      step++;
    end
  end

  task automatic do_reset();
    reset_in = 1'b0;
    exp_q.delete();
    #2;
    chk_zero("abort_reset");
    @(posedge clk); #1;
    chk_zero("held_reset");
    reset_in = 1'b1;
    @(posedge clk); #1;
    chk("rel_f1_addr", int'(bus.mux_address), 0);
    chk("rel_f1_ula", int'(bus.ula), 1);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input bit ovf, input int w,
                     input bit dzo, input int dz,
                     input int abort_at);
    int n;
    build(op, fn, ovf, w, dzo, dz);
    n = exp_q.size();
    cur_op = op;
    cur_fn = fn;
    step = 0;
    bus.opcode = op;
    bus.immediate = {10'($urandom), fn};
    for (int c = 0; c < n; c++) begin
      if (c == abort_at) begin
        do_reset();
        return;
      end
      bus.overflow = c == 4 ? ovf : 1'($urandom);
      bus.mult_stop = c < 5 ? 1'($urandom) : 1'(c >= 5 + w);
      bus.div_stop  = c < 5 ? 1'($urandom) : 1'(c >= 5 + w);
      bus.div_zero  = c < 5 ? 1'($urandom)
                            : 1'(dzo && c >= 5 + dz);
      bus.zero_div  = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_in = 1'b0;
    bus.opcode = '0;
    bus.immediate = '0;
    bus.overflow = 1'b0;
    bus.zero_div = 1'b0;
    bus.mult_stop = 1'b0;
    bus.div_stop = 1'b0;
    bus.div_zero = 1'b0;
    rfn = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h00, 6'h03, 6'h08,
            6'h10, 6'h12, 6'h18, 6'h1A, 6'h05, 6'h3F};
    iop = '{6'h08, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F,
            6'h02, 6'h03, 6'h3F};

    build(6'h00, 6'h20, 1'b0, 0, 1'b0, 0);
    chk("pin_add_len", exp_q.size(), 6);
    chk("pin_add_ula", int'(exp_q[4].ula), 1);
    chk("pin_add_wr", int'(exp_q[5].mux_register_wr), 1);
    build(6'h00, 6'h00, 1'b0, 0, 1'b0, 0);
    chk("pin_sll_len", exp_q.size(), 7);
    build(6'h02, 6'h00, 1'b0, 0, 1'b0, 0);
    chk("pin_j_len", exp_q.size(), 5);
    build(6'h00, 6'h20, 1'b1, 0, 1'b0, 0);
    chk("pin_ovf_len", exp_q.size(), 9);
    chk("pin_ovf_vec", int'(exp_q[5].mux_address), 3);
    build(6'h3F, 6'h00, 1'b0, 0, 1'b0, 0);
    chk("pin_inv_vec", int'(exp_q[4].mux_address), 2);
    build(6'h00, 6'h18, 1'b0, 2, 1'b0, 0);
`ifdef CU_MULT_DIV_EN
    chk("pin_mult_len", exp_q.size(), 9);
`else
    chk("pin_mult_len", exp_q.size(), 8);
`endif
    exp_q.delete();

    @(posedge clk); #1;
    chk_zero("reset");
    @(posedge clk); #1;
    reset_in = 1'b1;
    @(posedge clk); #1;
    chk("f1_addr", int'(bus.mux_address), 0);
    chk("f1_ula", int'(bus.ula), 1);
    chk("f1_ula1", int'(bus.mux_ula1), 1);
    chk("f1_ula2", int'(bus.mux_ula2), 1);
    armed = 1'b1;

    run(6'h00, 6'h20, 1'b0, 0, 1'b0, 0, -1);
    run(6'h00, 6'h20, 1'b1, 0, 1'b0, 0, -1);
    run(6'h00, 6'h18, 1'b0, 2, 1'b0, 0, -1);
    run(6'h00, 6'h1A, 1'b0, 5, 1'b1, 1, -1);
    run(6'h00, 6'h1A, 1'b0, 0, 1'b0, 0, -1);
    run(6'h3F, 6'h00, 1'b0, 0, 1'b0, 0, -1);
    run(6'h00, 6'h18, 1'b0, 10, 1'b0, 0, 6);
    run(6'h00, 6'h20, 1'b0, 0, 1'b0, 0, 3);
    run(6'h23, 6'h11, 1'b0, 0, 1'b0, 0, -1);
    run(6'h03, 6'h00, 1'b0, 0, 1'b0, 0, -1);
    run(6'h00, 6'h03, 1'b0, 0, 1'b0, 0, -1);
    run(6'h00, 6'h05, 1'b0, 0, 1'b0, 0, -1);
    run(6'h08, 6'h2A, 1'b1, 0, 1'b0, 0, -1);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      int ab;
      if ($urandom_range(0, 1) == 0) begin
        op = 6'h00;
        fn = rfn[$urandom_range(0, 12)];
      end else begin
        op = iop[$urandom_range(0, 8)];
        fn = 6'($urandom);
      end
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      ab = $urandom_range(0, 15) == 0 ? $urandom_range(0, 9) : -1;
      run(op, fn, 1'($urandom), $urandom_range(0, 4),
          1'($urandom), $urandom_range(0, 4), ab);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
